// File: rtl/ula_div_pkg.sv
// Shared state encoding and sizing helper for the sequential signed divider.
package ula_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Iteration counter must hold the value NUBITS itself.
  function automatic int cnt_w(input int nubits);
    return $clog2(nubits + 1);
  endfunction

endpackage

// File: rtl/ula_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into R,
// subtract D when it fits and record the quotient bit.
module ula_div_step #(
  parameter int NUBITS = 32
) (
  input  logic [NUBITS:0]   r,
  input  logic [NUBITS-1:0] q,
  input  logic [NUBITS-1:0] d,
  output logic [NUBITS:0]   r_next,
  output logic [NUBITS-1:0] q_next
);

  always_comb begin
    q_next = {q[NUBITS-2:0], 1'b0};
    r_next = {r[NUBITS-1:0], q[NUBITS-1]};
    if ({r, q[NUBITS-1]} >= {2'b00, d}) begin
      r_next    = (NUBITS+1)'({r, q[NUBITS-1]} - {2'b00, d});
      q_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/ula_div_seq.sv
// Multi-cycle signed divider (C semantics: truncating quotient, remainder takes the
// dividend's sign). Define ULA_DIV_EARLY_EN to skip the leading zeros of |in1|.
module ula_div_seq
  import ula_div_pkg::*;
#(
  parameter int NUBITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUBITS-1:0] in1,
  input  logic [NUBITS-1:0] in2,
  output logic              busy,
  output logic              done,
  output logic [NUBITS-1:0] quo,
  output logic [NUBITS-1:0] rem,
  output logic              div_zero,
  output state_e            dbg_state
);

  // Handshake: start is taken only while IDLE (busy low); busy stays high until the
  // cycle done pulses; quo/rem/div_zero are valid from done until the next accept.

  localparam int CNT_W = cnt_w(NUBITS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUBITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUBITS:0]   r_q, r_d, r_step;
  logic [NUBITS-1:0] q_q, q_d, q_step;
  logic [NUBITS-1:0] d_q, d_d;
  logic              nsign_q, nsign_d;
  logic              qsign_q, qsign_d;
  logic              dz_q, dz_d;
  logic [NUBITS-1:0] quo_q, quo_d, rem_q, rem_d;
  logic              div_zero_q, div_zero_d;
  logic              done_q, done_d;

  logic [NUBITS-1:0] abs1, abs2, q_init;
  logic [CNT_W-1:0]  iter_init;
  logic              accept;

  assign abs1   = in1[NUBITS-1] ? -in1 : in1;
  assign abs2   = in2[NUBITS-1] ? -in2 : in2;
  assign accept = (state_q == IDLE) && start;

`ifdef ULA_DIV_EARLY_EN
  logic [CNT_W-1:0] lz;

  always_comb begin
    lz = CNT_FULL;
    for (int i = 0; i < NUBITS; i++) begin
      if (abs1[i]) lz = CNT_W'(NUBITS - 1 - i);
    end
  end

  // Leading zeros would only shift zeros into R, so they are skipped outright.
  assign q_init    = abs1 << lz;
  assign iter_init = (lz == CNT_FULL) ? CNT_ONE : (CNT_FULL - lz);
`else
  assign q_init    = abs1;
  assign iter_init = CNT_FULL;
`endif

  ula_div_step #(.NUBITS(NUBITS)) u_step (
    .r      (r_q),
    .q      (q_q),
    .d      (d_q),
    .r_next (r_step),
    .q_next (q_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      r_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      nsign_q    <= 1'b0;
      qsign_q    <= 1'b0;
      dz_q       <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      q_q        <= q_d;
      d_q        <= d_d;
      nsign_q    <= nsign_d;
      qsign_q    <= qsign_d;
      dz_q       <= dz_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (in2 == '0) ? FIN : CALC;
      CALC:    if (cnt_q == CNT_ONE) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    r_d        = r_q;
    q_d        = q_q;
    d_d        = d_q;
    nsign_d    = nsign_q;
    qsign_d    = qsign_q;
    dz_d       = dz_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    if (accept) begin
      // On divide by zero R carries |in1| so the sign fix-up in FIN restores in1.
      r_d     = (in2 == '0) ? {1'b0, abs1} : '0;
      q_d     = q_init;
      d_d     = abs2;
      cnt_d   = iter_init;
      nsign_d = in1[NUBITS-1];
      qsign_d = in1[NUBITS-1] ^ in2[NUBITS-1];
      dz_d    = (in2 == '0);
    end else if (state_q == CALC) begin
      r_d   = r_step;
      q_d   = q_step;
      cnt_d = cnt_q - CNT_ONE;
    end else if (state_q == FIN) begin
      quo_d      = dz_q ? '1 : (qsign_q ? -q_q : q_q);
      rem_d      = nsign_q ? -r_q[NUBITS-1:0] : r_q[NUBITS-1:0];
      div_zero_d = dz_q;
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done_d    = (state_q == FIN);
    dbg_state = state_q;
  end

  assign done     = done_q;
  assign quo      = quo_q;
  assign rem      = rem_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_ula_div_seq.sv
// Self-checking bench for ula_div_seq: directed scenarios plus random operands,
// checked against a C-semantics arithmetic model.
module tb_ula_div_seq;
  import ula_div_pkg::*;

  localparam int W      = 32;
  localparam int BUDGET = 200;

  logic         clk, rst, start;
  logic [W-1:0] in1, in2;
  logic         busy, done, div_zero;
  logic [W-1:0] quo, rem;
  state_e       dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*W:0] exp_q[$];

  ula_div_seq #(.NUBITS(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in1       (in1),
    .in2       (in2),
    .busy      (busy),
    .done      (done),
    .quo       (quo),
    .rem       (rem),
    .div_zero  (div_zero),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [W-1:0] qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      qq = '1;
      return {qq, a, 1'b1};
    end
    q  = sa / sb;
    r  = sa % sb;
    qq = W'(q);
    rr = W'(r);
    return {qq, rr, 1'b0};
  endfunction

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] mag;
    int bits;
    mag  = a[W-1] ? -a : a;
    bits = 1;
    for (int i = 0; i < W; i++) if (mag[i]) bits = i + 1;
    if (b == '0) return 1;
`ifdef ULA_DIV_EARLY_EN
    return bits + 1;
`else
    return (bits > W) ? bits : W + 1;
`endif
  endfunction

  function automatic logic [W-1:0] pick_operand(input bit allow_zero);
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0:       v = $urandom;
      1:       v = W'($urandom_range(0, 300));
      2:       v = -W'($urandom_range(1, 300));
      3:       v = 32'h8000_0000;
      4:       v = '1;
      5:       v = 32'h7fff_ffff;
      default: v = allow_zero ? '0 : W'($urandom_range(1, 9));
    endcase
    return v;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge where done is seen (or budget expires).
  task automatic issue_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] oq, output logic [W-1:0] orr,
                          output logic odz, output int lat, output int busy_n);
    start = 1'b1; in1 = a; in2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; in1 = $urandom; in2 = $urandom;
    lat = -1; busy_n = 0;
    for (int k = 0; k <= BUDGET; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_n++;
    end
    oq = quo; orr = rem; odz = div_zero;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; start = 1'b0; in1 = '0; in2 = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, div_zero, quo, rem} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b dz=%b quo=%h rem=%h, want all zero",
               busy, done, div_zero, quo, rem);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== IDLE || busy !== 1'b0)
      $display("FAIL reset_idle: got state=%0d busy=%b, want state=0 busy=0", dbg_state, busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [W-1:0] oq, orr; logic odz; int lat, bn; logic [2*W:0] e;
    exp_q.push_back(model(100, 7));
    issue_op(100, 7, oq, orr, odz, lat, bn);
    e = exp_q.pop_front();
    n_checks++;
    if ({oq, orr, odz} !== e)
      $display("FAIL basic_result: got quo=%0d rem=%0d dz=%b, want quo=%0d rem=%0d dz=%b",
               $signed(oq), $signed(orr), odz, $signed(e[2*W:W+1]), $signed(e[W:1]), e[0]);
    else n_pass++;
    n_checks++;
    if (lat != exp_lat(100, 7))
      $display("FAIL basic_latency: got %0d edges, want %0d", lat, exp_lat(100, 7));
    else n_pass++;
    n_checks++;
    if (bn != exp_lat(100, 7))
      $display("FAIL basic_busy_cycles: got %0d, want %0d", bn, exp_lat(100, 7));
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL done_single_pulse: got done=%b busy=%b one cycle later, want 0 0", done, busy);
    else n_pass++;
  endtask

  task automatic test_signed();
    logic [W-1:0] ta[3], tb[3];
    logic [W-1:0] oq, orr; logic odz; int lat, bn; logic [2*W:0] e;
    ta[0] = -100; tb[0] = 7;
    ta[1] = 100;  tb[1] = -7;
    ta[2] = -100; tb[2] = -7;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(ta[i], tb[i]));
      issue_op(ta[i], tb[i], oq, orr, odz, lat, bn);
      e = exp_q.pop_front();
      n_checks++;
      if ({oq, orr, odz, lat} !== {e, exp_lat(ta[i], tb[i])})
        $display("FAIL signed_%0d: got quo=%0d rem=%0d dz=%b lat=%0d, want quo=%0d rem=%0d dz=%b lat=%0d",
                 i, $signed(oq), $signed(orr), odz, lat,
                 $signed(e[2*W:W+1]), $signed(e[W:1]), e[0], exp_lat(ta[i], tb[i]));
      else n_pass++;
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] oq, orr; logic odz; int lat, bn; logic [2*W:0] e;
    exp_q.push_back(model(5, 0));
    issue_op(5, 0, oq, orr, odz, lat, bn);
    e = exp_q.pop_front();
    n_checks++;
    if ({oq, orr, odz} !== e)
      $display("FAIL div_zero_result: got quo=%h rem=%0d dz=%b, want quo=%h rem=%0d dz=%b",
               oq, $signed(orr), odz, e[2*W:W+1], $signed(e[W:1]), e[0]);
    else n_pass++;
    n_checks++;
    if (lat != exp_lat(5, 0) || bn != 1)
      $display("FAIL div_zero_timing: got lat=%0d busy_cycles=%0d, want lat=%0d busy_cycles=1",
               lat, bn, exp_lat(5, 0));
    else n_pass++;
    exp_q.push_back(model(9, 3));
    issue_op(9, 3, oq, orr, odz, lat, bn);
    e = exp_q.pop_front();
    n_checks++;
    if ({oq, orr, odz} !== e)
      $display("FAIL div_zero_clear: got quo=%0d rem=%0d dz=%b, want quo=%0d rem=%0d dz=%b",
               $signed(oq), $signed(orr), odz, $signed(e[2*W:W+1]), $signed(e[W:1]), e[0]);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [W-1:0] ta[2], tb[2];
    logic [W-1:0] oq, orr; logic odz; int lat, bn; logic [2*W:0] e;
    ta[0] = 32'h8000_0000; tb[0] = '1;
    ta[1] = 32'h8000_0000; tb[1] = 1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(model(ta[i], tb[i]));
      issue_op(ta[i], tb[i], oq, orr, odz, lat, bn);
      e = exp_q.pop_front();
      n_checks++;
      if ({oq, orr, odz} !== e)
        $display("FAIL overflow_%0d: got quo=%h rem=%h dz=%b, want quo=%h rem=%h dz=%b",
                 i, oq, orr, odz, e[2*W:W+1], e[W:1], e[0]);
      else n_pass++;
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] oq, orr; logic odz; int lat, bn, k, inj; bit seen; logic [2*W:0] e;
    inj = (exp_lat(100, 7) > 11) ? 10 : 3;
    exp_q.push_back(model(100, 7));
    start = 1'b1; in1 = 100; in2 = 7;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0; seen = 1'b0;
    while (k <= BUDGET && !seen) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        if (k == inj) begin start = 1'b1; in1 = 50; in2 = 5; end
        else start = 1'b0;
        @(posedge clk);
        k++;
      end
    end
    start = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (!seen || k != exp_lat(100, 7) || {quo, rem, div_zero} !== e)
      $display("FAIL ignore_start_first: got seen=%b lat=%0d quo=%0d rem=%0d, want lat=%0d quo=%0d rem=%0d",
               seen, k, $signed(quo), $signed(rem), exp_lat(100, 7),
               $signed(e[2*W:W+1]), $signed(e[W:1]));
    else n_pass++;
    exp_q.push_back(model(50, 5));
    issue_op(50, 5, oq, orr, odz, lat, bn);
    e = exp_q.pop_front();
    n_checks++;
    if ({oq, orr, odz} !== e)
      $display("FAIL ignore_start_next: got quo=%0d rem=%0d, want quo=%0d rem=%0d",
               $signed(oq), $signed(orr), $signed(e[2*W:W+1]), $signed(e[W:1]));
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] oq, orr; logic odz; int lat, bn, inj; bit stray; logic [2*W:0] e;
    inj = (exp_lat(100, 7) > 16) ? 15 : 3;
    start = 1'b1; in1 = 100; in2 = 7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (inj) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL async_reset_inflight: got busy=%b, want 1", busy);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, div_zero, quo, rem} !== '0)
      $display("FAIL async_reset_outputs: got busy=%b done=%b dz=%b quo=%h rem=%h, want all zero",
               busy, done, div_zero, quo, rem);
    else n_pass++;
    stray = 1'b0;
    repeat (2) begin @(negedge clk); if (done) stray = 1'b1; end
    rst = 1'b1;
    repeat (40) begin @(negedge clk); if (done || busy) stray = 1'b1; end
    n_checks++;
    if (stray) $display("FAIL async_reset_no_done: got done/busy after abandoned op, want none");
    else n_pass++;
    exp_q.push_back(model(1, 1));
    issue_op(1, 1, oq, orr, odz, lat, bn);
    e = exp_q.pop_front();
    n_checks++;
    if ({oq, orr, odz} !== e || lat != exp_lat(1, 1))
      $display("FAIL async_reset_recover: got quo=%0d rem=%0d lat=%0d, want quo=%0d rem=%0d lat=%0d",
               $signed(oq), $signed(orr), lat, $signed(e[2*W:W+1]), $signed(e[W:1]), exp_lat(1, 1));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] oq, orr; logic odz; int lat, bn; logic [2*W:0] e;
    logic [W-1:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = pick_operand(1'b1);
      b = pick_operand(i == 2);
      exp_q.push_back(model(a, b));
      issue_op(a, b, oq, orr, odz, lat, bn);
      e = exp_q.pop_front();
      n_checks++;
      if ({oq, orr, odz} !== e || lat != exp_lat(a, b))
        $display("FAIL back_to_back_%0d: %h/%h got quo=%h rem=%h dz=%b lat=%0d, want quo=%h rem=%h dz=%b lat=%0d",
                 i, a, b, oq, orr, odz, lat, e[2*W:W+1], e[W:1], e[0], exp_lat(a, b));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] oq, orr; logic odz; int lat, bn; logic [2*W:0] e;
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = pick_operand(1'b1);
      b = pick_operand(1'b1);
      exp_q.push_back(model(a, b));
      issue_op(a, b, oq, orr, odz, lat, bn);
      e = exp_q.pop_front();
      n_checks++;
      if ({oq, orr, odz} !== e || lat != exp_lat(a, b) || bn != lat)
        $display("FAIL random_%0d: %h/%h got quo=%h rem=%h dz=%b lat=%0d busy=%0d, want quo=%h rem=%h dz=%b lat=%0d",
                 i, a, b, oq, orr, odz, lat, bn, e[2*W:W+1], e[W:1], e[0], exp_lat(a, b));
      else n_pass++;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
